pe_psum_accum: RTL and testbench

Parametrised partial-sum collector for a PE column. It gathers exactly one signed value from each of `N_CH` processing-element channels per round; values may arrive in any order, and several may arrive in the same cycle. Each round's total goes into a registered output with a valid/ready handshake, using either wrap-around or saturating arithmetic. It sits between the PE array outputs and the downstream activation/write-back stage, and replaces the fixed three-input, fixed-order adder.

---
 rtl/pe_pkg.sv | 40 ++++
 rtl/pe_psum_adder_tree.sv | 26 ++
 rtl/pe_psum_accum.sv | 167 ++++++++++++++++
 tb/tb_pe_psum_accum.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the PE partial-sum collector.
//   - default channel / accumulator widths
//   - collector FSM state encoding
//   - width-parameterised saturating clamp helpers (operate on a 64-bit
//     signed carrier; callers size-cast the result down to their width)
package pe_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ACC_W_DEF  = 16;

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_e;

  // Largest value representable in a w-bit signed number.
  function automatic logic signed [63:0] sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in a w-bit signed number.
  function automatic logic signed [63:0] sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Clamp x into the w-bit signed range.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] x,
                                                  input int unsigned       w);
    if (x > sat_max(w)) return sat_max(w);
    if (x < sat_min(w)) return sat_min(w);
    return x;
  endfunction

  // True when sat_clamp(x, w) would alter x.
  function automatic logic sat_hit(input logic signed [63:0] x,
                                   input int unsigned       w);
    return (x > sat_max(w)) || (x < sat_min(w));
  endfunction

endpackage

// File: rtl/pe_psum_adder_tree.sv
// Combinational masked sum of N_CH signed channel values.
// Ports:
//   en_i   [N_CH]          per-channel include mask
//   data_i [N_CH*DATA_W]   channel i at [i*DATA_W +: DATA_W], two's complement
//   sum_o  [SUM_W]         sign-extended sum of the enabled channels
// SUM_W must be at least DATA_W + $clog2(N_CH+1) so the sum cannot overflow.
module pe_psum_adder_tree #(
  parameter int unsigned N_CH   = 3,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SUM_W  = 18
) (
  input  logic [N_CH-1:0]        en_i,
  input  logic [N_CH*DATA_W-1:0] data_i,
  output logic signed [SUM_W-1:0] sum_o
);

  always_comb begin
    sum_o = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (en_i[i]) begin
        sum_o = sum_o + SUM_W'($signed(data_i[i*DATA_W +: DATA_W]));
      end
    end
  end

endmodule

// File: rtl/pe_psum_accum.sv
// Partial-sum collector for a PE column. Gathers one signed value from each
// of N_CH channels per round (any order, any grouping per cycle), then
// presents the round total on a registered valid/ready output. A second
// completed round can be parked (HOLD) while the output register is full.
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   done_in   [N_CH]       per-channel strobe
//   data_in   [N_CH*DATA_W] channel values, channel i at [i*DATA_W +: DATA_W]
//   in_ready               strobes are accepted this cycle
//   out_valid / out_ready  result handshake
//   value     [ACC_W]      round sum (wrapped or clamped per SAT_EN)
//   sat                    some add in the round clamped (SAT_EN=1 only)
//   err_dup                sticky: strobe on an already-received channel
//   err_drop               sticky: strobe while in_ready=0
module pe_psum_accum
  import pe_pkg::*;
#(
  parameter int unsigned N_CH   = 3,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned SAT_EN = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CH-1:0]        done_in,
  input  logic [N_CH*DATA_W-1:0] data_in,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       value,
  output logic                   sat,
  output logic                   err_dup,
  output logic                   err_drop
);

  localparam int unsigned SUM_W = ACC_W + $clog2(N_CH + 1);

  state_e                   state_q, state_d;
  logic [N_CH-1:0]          mask_q, mask_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     rsat_q, rsat_d;
  logic [ACC_W-1:0]         value_q, value_d;
  logic                     sat_q, sat_d;
  logic                     ov_q, ov_d;
  logic                     edup_q, edup_d;
  logic                     edrop_q, edrop_d;

  logic [N_CH-1:0]          accept;
  logic [N_CH-1:0]          mask_new;
  logic signed [SUM_W-1:0]  tree_sum;
  logic signed [SUM_W-1:0]  wide;
  logic signed [ACC_W-1:0]  acc_next;
  logic                     clamp_hit;
  logic                     complete;
  logic                     out_free;
  logic                     dup;
  logic                     drop;

  assign in_ready = (state_q == ST_COLLECT);
  assign accept   = done_in & ~mask_q & {N_CH{in_ready}};
  assign mask_new = mask_q | accept;
  assign complete = in_ready && (&mask_new);
  assign out_free = !ov_q || out_ready;
  assign dup      = in_ready && (|(done_in & mask_q));
  assign drop     = !in_ready && (|done_in);

  pe_psum_adder_tree #(
    .N_CH   (N_CH),
    .DATA_W (DATA_W),
    .SUM_W  (SUM_W)
  ) u_tree (
    .en_i   (accept),
    .data_i (data_in),
    .sum_o  (tree_sum)
  );

  // Whole-cycle sum is formed wide, then wrapped or clamped once, so a
  // transient overflow between channels landing together never clamps.
  assign wide = SUM_W'(acc_q) + tree_sum;

  always_comb begin
    acc_next  = wide[ACC_W-1:0];
    clamp_hit = 1'b0;
    if (SAT_EN != 0) begin
      acc_next  = ACC_W'(sat_clamp(64'(wide), ACC_W));
      clamp_hit = sat_hit(64'(wide), ACC_W);
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    acc_d   = acc_q;
    rsat_d  = rsat_q;
    value_d = value_q;
    sat_d   = sat_q;
    ov_d    = ov_q;
    edup_d  = edup_q | dup;
    edrop_d = edrop_q | drop;

    // Consumption first; a load below in the same cycle overrides it.
    if (ov_q && out_ready) ov_d = 1'b0;

    unique case (state_q)
      ST_COLLECT: begin
        acc_d  = acc_next;
        mask_d = mask_new;
        rsat_d = rsat_q | clamp_hit;
        if (complete) begin
          if (out_free) begin
            value_d = acc_next;
            sat_d   = rsat_q | clamp_hit;
            ov_d    = 1'b1;
            acc_d   = '0;
            mask_d  = '0;
            rsat_d  = 1'b0;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          value_d = acc_q;
          sat_d   = rsat_q;
          ov_d    = 1'b1;
          acc_d   = '0;
          mask_d  = '0;
          rsat_d  = 1'b0;
          state_d = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_COLLECT;
      mask_q  <= '0;
      acc_q   <= '0;
      rsat_q  <= 1'b0;
      value_q <= '0;
      sat_q   <= 1'b0;
      ov_q    <= 1'b0;
      edup_q  <= 1'b0;
      edrop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      acc_q   <= acc_d;
      rsat_q  <= rsat_d;
      value_q <= value_d;
      sat_q   <= sat_d;
      ov_q    <= ov_d;
      edup_q  <= edup_d;
      edrop_q <= edrop_d;
    end
  end

  assign out_valid = ov_q;
  assign value     = value_q;
  assign sat       = sat_q;
  assign err_dup   = edup_q;
  assign err_drop  = edrop_q;

endmodule

// File: tb/tb_pe_psum_accum.sv
// Bench for pe_psum_accum: one wrapping and one saturating instance driven
// by the same stimulus, each compared every cycle against a queue-based
// model of completed rounds, plus directed value checks.
module tb_pe_psum_accum;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  done_in;
  logic [47:0] data_in;
  logic        out_ready;

  logic        in_ready_w, ov_w, sat_w, edup_w, edrop_w;
  logic [15:0] val_w;
  logic        in_ready_s, ov_s, sat_s, edup_s, edrop_s;
  logic [15:0] val_s;

  always #5 clk = ~clk;

  pe_psum_accum #(.N_CH(3), .DATA_W(16), .ACC_W(16), .SAT_EN(0)) dut_w (
    .clk(clk), .reset(reset), .done_in(done_in), .data_in(data_in),
    .in_ready(in_ready_w), .out_valid(ov_w), .out_ready(out_ready),
    .value(val_w), .sat(sat_w), .err_dup(edup_w), .err_drop(edrop_w)
  );

  pe_psum_accum #(.N_CH(3), .DATA_W(16), .ACC_W(16), .SAT_EN(1)) dut_s (
    .clk(clk), .reset(reset), .done_in(done_in), .data_in(data_in),
    .in_ready(in_ready_s), .out_valid(ov_s), .out_ready(out_ready),
    .value(val_s), .sat(sat_s), .err_dup(edup_s), .err_drop(edrop_s)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: up to two finished rounds waiting (output register + parked one).
  typedef struct { int v; bit s; } res_t;
  res_t     slot[2][2];
  int       cnt[2];
  int       acc[2];
  bit       rsat[2];
  bit [2:0] recv[2];
  bit       edup[2], edrop[2];
  int       last_v[2];
  bit       last_s[2];

  function automatic int wrap16(input int x);
    logic signed [15:0] t;
    t = x[15:0];
    return int'(t);
  endfunction

  task automatic model_step(input int m, input bit rst, input bit [2:0] dn,
                            input logic [47:0] d, input bit ordy);
    bit   rdy, consume, any, push;
    int   sum, t;
    res_t nr;
    if (rst) begin
      cnt[m] = 0; acc[m] = 0; rsat[m] = 0; recv[m] = '0;
      edup[m] = 0; edrop[m] = 0; last_v[m] = 0; last_s[m] = 0;
      return;
    end
    rdy     = (cnt[m] < 2);
    consume = (cnt[m] > 0) && ordy;
    push    = 0;
    nr.v = 0; nr.s = 0;
    if (!rdy && dn != 0) edrop[m] = 1;
    if (rdy) begin
      any = 0; sum = 0;
      for (int i = 0; i < 3; i++) begin
        if (dn[i]) begin
          if (recv[m][i]) edup[m] = 1;
          else begin
            recv[m][i] = 1;
            any = 1;
            sum += int'($signed(d[i*16 +: 16]));
          end
        end
      end
      if (any) begin
        t = acc[m] + sum;
        if (m == 1) begin
          if (t > 32767) begin t = 32767; rsat[m] = 1; end
          else if (t < -32768) begin t = -32768; rsat[m] = 1; end
        end else begin
          t = wrap16(t);
        end
        acc[m] = t;
      end
      if (recv[m] == 3'b111) begin
        nr.v = acc[m]; nr.s = rsat[m]; push = 1;
        acc[m] = 0; rsat[m] = 0; recv[m] = '0;
      end
    end
    if (consume) begin
      last_v[m] = slot[m][0].v; last_s[m] = slot[m][0].s;
      slot[m][0] = slot[m][1];
      cnt[m]--;
    end
    if (push) begin
      slot[m][cnt[m]] = nr;
      cnt[m]++;
    end
  endtask

  task automatic check_model();
    for (int m = 0; m < 2; m++) begin
      logic ir, ov, st, ed, edr;
      logic [15:0] vl;
      int ev; bit es;
      string p;
      p = (m == 0) ? "w" : "s";
      ir = (m == 0) ? in_ready_w : in_ready_s;
      ov = (m == 0) ? ov_w : ov_s;
      st = (m == 0) ? sat_w : sat_s;
      ed = (m == 0) ? edup_w : edup_s;
      edr = (m == 0) ? edrop_w : edrop_s;
      vl = (m == 0) ? val_w : val_s;
      ev = (cnt[m] > 0) ? slot[m][0].v : last_v[m];
      es = (cnt[m] > 0) ? slot[m][0].s : last_s[m];
      check({p, "_in_ready"}, longint'(ir), longint'(cnt[m] < 2));
      check({p, "_out_valid"}, longint'(ov), longint'(cnt[m] > 0));
      check({p, "_value"}, longint'($signed(vl)), longint'(ev));
      check({p, "_sat"}, longint'(st), longint'(es));
      check({p, "_err_dup"}, longint'(ed), longint'(edup[m]));
      check({p, "_err_drop"}, longint'(edr), longint'(edrop[m]));
    end
  endtask

  // Called on a falling edge: compare, drive, advance the model, step a cycle.
  task automatic cycle(input bit rst, input bit [2:0] dn, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] c, input bit ordy);
    check_model();
    reset     = rst;
    done_in   = dn;
    data_in   = {c, b, a};
    out_ready = ordy;
    model_step(0, rst, dn, {c, b, a}, ordy);
    model_step(1, rst, dn, {c, b, a}, ordy);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; done_in = '0; data_in = '0; out_ready = 1'b0;
    model_step(0, 1, '0, '0, 0);
    model_step(1, 1, '0, '0, 0);
    @(posedge clk);
    @(negedge clk);

    // Reset values
    check("rst_in_ready", longint'(in_ready_w), 1);
    check("rst_out_valid", longint'(ov_w), 0);
    check("rst_value", longint'(val_w), 0);
    check("rst_sat", longint'(sat_s), 0);
    check("rst_err_dup", longint'(edup_w), 0);
    check("rst_err_drop", longint'(edrop_s), 0);
    cycle(1, 3'b000, 0, 0, 0, 1);

    // Ordered arrival 5, 7, -2
    cycle(0, 3'b001, 16'd5, 0, 0, 1);
    cycle(0, 3'b010, 0, 16'd7, 0, 1);
    check("ord_not_yet", longint'(ov_w), 0);
    cycle(0, 3'b100, 0, 0, -16'sd2, 1);
    check("ord_valid", longint'(ov_w), 1);
    check("ord_value", longint'($signed(val_w)), 10);
    cycle(0, 3'b000, 0, 0, 0, 1);
    check("ord_pulse_end", longint'(ov_w), 0);

    // Out of order, two channels together
    cycle(0, 3'b100, 0, 0, 16'd100, 1);
    cycle(0, 3'b011, 16'd1, 16'd2, 0, 1);
    check("ooo_value", longint'($signed(val_w)), 103);
    check("ooo_valid", longint'(ov_s), 1);

    // All three at once
    cycle(0, 3'b111, 16'd1, 16'd2, 16'd3, 1);
    check("all3_value", longint'($signed(val_s)), 6);

    // Saturation vs wrap
    cycle(0, 3'b111, 16'd30000, 16'd30000, -16'sd5, 1);
    check("sat_value", longint'($signed(val_s)), 32767);
    check("sat_flag", longint'(sat_s), 1);
    check("wrap_value", longint'($signed(val_w)), -5541);
    check("wrap_flag", longint'(sat_w), 0);
    cycle(0, 3'b000, 0, 0, 0, 1);

    // Backpressure
    cycle(0, 3'b111, 16'd1, 16'd1, 16'd1, 0);
    check("bp_first", longint'($signed(val_w)), 3);
    cycle(0, 3'b111, 16'd2, 16'd2, 16'd2, 0);
    check("bp_hold_value", longint'($signed(val_w)), 3);
    check("bp_hold_ready", longint'(in_ready_w), 0);
    cycle(0, 3'b001, 16'd7, 0, 0, 0);
    check("bp_err_drop", longint'(edrop_w), 1);
    cycle(0, 3'b000, 0, 0, 0, 1);
    check("bp_release_value", longint'($signed(val_w)), 6);
    check("bp_release_ready", longint'(in_ready_w), 1);
    check("bp_release_valid", longint'(ov_w), 1);
    cycle(0, 3'b000, 0, 0, 0, 1);

    // Duplicate strobe
    check("dup_before", longint'(edup_w), 0);
    cycle(0, 3'b001, 16'd4, 0, 0, 1);
    cycle(0, 3'b001, 16'd9, 0, 0, 1);
    cycle(0, 3'b010, 0, 16'd1, 0, 1);
    cycle(0, 3'b100, 0, 0, 16'd1, 1);
    check("dup_flag", longint'(edup_w), 1);
    check("dup_value", longint'($signed(val_w)), 6);

    // Reset mid-round
    cycle(0, 3'b001, 16'd50, 0, 0, 1);
    cycle(1, 3'b000, 0, 0, 0, 1);
    check("mrst_err_dup", longint'(edup_w), 0);
    check("mrst_err_drop", longint'(edrop_w), 0);
    check("mrst_value", longint'(val_s), 0);
    cycle(0, 3'b001, 16'd1, 0, 0, 1);
    cycle(0, 3'b010, 0, 16'd2, 0, 1);
    cycle(0, 3'b100, 0, 0, 16'd3, 1);
    check("mrst_round", longint'($signed(val_w)), 6);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      bit [2:0]    dn;
      logic [15:0] a, b, c;
      bit          ordy, rst;
      dn   = ($urandom_range(0, 2) == 0) ? 3'b111 : 3'($urandom_range(0, 7));
      a    = 16'($urandom);
      b    = 16'($urandom);
      c    = 16'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      rst  = ($urandom_range(0, 149) == 0);
      cycle(rst, dn, a, b, c, ordy);
    end
    check_model();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
